// File: rtl/extend_pkg.sv
// ---------------------------------------------------------------------------
// extend_pkg
// Shared types for the immediate-extension pipeline stage.
//   ext_mode_t  : how an I-bit immediate is widened to N bits
//   ext_state_t : occupancy of the output/skid register pair
// ---------------------------------------------------------------------------
package extend_pkg;

    typedef enum logic [1:0] {
        EXT_ZERO   = 2'b00,
        EXT_SIGN   = 2'b01,
        EXT_UPPER  = 2'b10,
        EXT_BRANCH = 2'b11
    } ext_mode_t;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b10
    } ext_state_t;

endpackage : extend_pkg

// File: rtl/extend_core.sv
// ---------------------------------------------------------------------------
// extend_core
// Purely combinational immediate widener.
// Ports:
//   a    in  I   raw immediate
//   mode in  2   ext_mode_t selecting zero / sign / upper / branch
//   y    out N   extended value
// ---------------------------------------------------------------------------
module extend_core
    import extend_pkg::*;
#(
    parameter int N = 32,
    parameter int I = 16
) (
    input  logic [I-1:0] a,
    input  ext_mode_t    mode,
    output logic [N-1:0] y
);

    logic [N-1:0] zext;
    logic [N-1:0] sext;
    logic [N-1:0] upper;
    logic [N-1:0] branch;

    assign zext   = {{(N-I){1'b0}}, a};
    assign sext   = {{(N-I){a[I-1]}}, a};
    assign upper  = {a, {(N-I){1'b0}}};
    // Two guard bits above the sign-extended immediate mean the shift
    // never pushes a significant bit out of the N-bit result.
    assign branch = {sext[N-3:0], 2'b00};

    always_comb begin
        y = zext;
        case (mode)
            EXT_ZERO:   y = zext;
            EXT_SIGN:   y = sext;
            EXT_UPPER:  y = upper;
            EXT_BRANCH: y = branch;
            default:    y = zext;
        endcase
    end

endmodule : extend_core

// File: rtl/extend_pipe.sv
// ---------------------------------------------------------------------------
// extend_pipe
// Registered immediate-extension stage with valid/ready handshake and a
// two-entry (output + skid) buffer, so it runs at full throughput inside a
// stalling pipeline. The extension is computed on the input side, so stored
// results never depend on later input values. A tag rides along unchanged.
// Ports:
//   clk        in  1  clock, rising edge
//   reset      in  1  synchronous, active-high
//   in_valid   in  1  upstream offers an immediate
//   in_ready   out 1  stage accepts this cycle (decoded from state only)
//   in_imm     in  I  raw immediate
//   in_mode    in  2  ext_mode_t
//   in_tag     in  T  sideband tag
//   out_valid  out 1  out_data/out_tag valid
//   out_ready  in  1  downstream accepts this cycle
//   out_data   out N  extended value
//   out_tag    out T  tag of out_data
// ---------------------------------------------------------------------------
module extend_pipe
    import extend_pkg::*;
#(
    parameter int N = 32,
    parameter int I = 16,
    parameter int T = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [I-1:0] in_imm,
    input  logic [1:0]   in_mode,
    input  logic [T-1:0] in_tag,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic [T-1:0] out_tag
);

    generate
        if (N < I + 2) begin : g_width_check
            $error("extend_pipe: N (%0d) must be at least I + 2 (%0d)", N, I + 2);
        end
        if (T < 1) begin : g_tag_check
            $error("extend_pipe: T (%0d) must be at least 1", T);
        end
    endgenerate

    ext_state_t   state_reg;
    ext_state_t   state_next;
    logic [N-1:0] out_data_reg;
    logic [T-1:0] out_tag_reg;
    logic [N-1:0] skid_data_reg;
    logic [T-1:0] skid_tag_reg;

    logic [N-1:0] ext_data;
    logic         acc;
    logic         drn;
    logic         load_out;
    logic         load_skid;
    logic         move_skid;

    extend_core #(
        .N (N),
        .I (I)
    ) u_core (
        .a    (in_imm),
        .mode (ext_mode_t'(in_mode)),
        .y    (ext_data)
    );

    // Both handshake flags come straight from the state register, which
    // keeps out_ready off any combinational path to in_ready.
    assign in_ready  = (state_reg != TWO);
    assign out_valid = (state_reg != EMPTY);
    assign out_data  = out_data_reg;
    assign out_tag   = out_tag_reg;

    assign acc = in_valid && in_ready;
    assign drn = out_valid && out_ready;

    always_comb begin
        state_next = state_reg;
        load_out   = 1'b0;
        load_skid  = 1'b0;
        move_skid  = 1'b0;
        case (state_reg)
            EMPTY: begin
                if (acc) begin
                    load_out   = 1'b1;
                    state_next = ONE;
                end
            end
            ONE: begin
                if (acc && !drn) begin
                    load_skid  = 1'b1;
                    state_next = TWO;
                end else if (acc && drn) begin
                    // New item replaces the one leaving on the same edge.
                    load_out   = 1'b1;
                end else if (drn) begin
                    state_next = EMPTY;
                end
            end
            TWO: begin
                if (drn) begin
                    move_skid  = 1'b1;
                    state_next = ONE;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= EMPTY;
            out_data_reg  <= '0;
            out_tag_reg   <= '0;
            skid_data_reg <= '0;
            skid_tag_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (load_out) begin
                out_data_reg <= ext_data;
                out_tag_reg  <= in_tag;
            end else if (move_skid) begin
                out_data_reg <= skid_data_reg;
                out_tag_reg  <= skid_tag_reg;
            end
            if (load_skid) begin
                skid_data_reg <= ext_data;
                skid_tag_reg  <= in_tag;
            end
        end
    end

endmodule : extend_pipe
